// File: rtl/mdu_hilo_pkg.sv
// Shared MDU definitions: state encoding, sizes, decoder bit positions, divide request payload.
package mdu_hilo_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = $clog2(DIV_ITERS);

  // Bit positions inside the 2-bit decoder fields
  localparam int unsigned MULT_S_BIT  = 0;
  localparam int unsigned MULT_U_BIT  = 1;
  localparam int unsigned DIV_S_BIT   = 0;
  localparam int unsigned DIV_U_BIT   = 1;
  localparam int unsigned MFHL_LO_BIT = 0;
  localparam int unsigned MFHL_HI_BIT = 1;
  localparam int unsigned MTHL_LO_BIT = 0;
  localparam int unsigned MTHL_HI_BIT = 1;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_e;

  typedef struct packed {
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
  } div_req_t;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
    return (is_signed && v[WIDTH-1]) ? ((~v) + WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// EX-stage decoder <-> MDU bundle: command fields, operands, HI/LO read data and stall.
interface mdu_hilo_if;
  import mdu_hilo_pkg::*;

  logic             in_valid;
  logic             cancel;
  logic [1:0]       MULT;
  logic [1:0]       DIV;
  logic [1:0]       MFHL;
  logic [1:0]       MTHL;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] hilo_rdata;
  logic             busy;
  logic             stall;

  modport master (
    output in_valid, cancel, MULT, DIV, MFHL, MTHL, src_a, src_b,
    input  hilo_rdata, busy, stall
  );

  modport slave (
    input  in_valid, cancel, MULT, DIV, MFHL, MTHL, src_a, src_b,
    output hilo_rdata, busy, stall
  );
endinterface

// File: rtl/mdu_hilo_div_iter_core.sv
// Iterative radix-2 restoring divider: latches magnitudes, runs 32 shift-subtract steps,
// then presents sign-fixed quotient/remainder during the FIX cycle.
module mdu_hilo_div_iter_core
  import mdu_hilo_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             cancel_i,
  input  div_req_t         req_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH:0]   trial;
  logic             take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MDU_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MDU_IDLE: if (start_i) state_d = MDU_RUN;
      MDU_RUN: begin
        if (cancel_i)          state_d = MDU_IDLE;
        else if (cnt_q == '0)  state_d = MDU_FIX;
      end
      MDU_FIX:  state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
  end

  // A cancel in FIX suppresses the HI/LO write
  always_comb begin
    busy_o = (state_q != MDU_IDLE);
    done_o = (state_q == MDU_FIX) && !cancel_i;
    quot_o = qneg_q ? ((~quo_q) + WIDTH'(1)) : quo_q;
    rem_o  = rneg_q ? ((~rem_q) + WIDTH'(1)) : rem_q;
  end

  // 33-bit partial remainder: previous remainder shifted left with the next dividend bit
  assign trial = {rem_q, quo_q[WIDTH-1]};
  assign take  = (trial >= {1'b0, dvs_q});

  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    if (state_q == MDU_IDLE && start_i) begin
      cnt_d  = CNT_W'(DIV_ITERS - 1);
      rem_d  = '0;
      quo_d  = magnitude(req_i.dividend, req_i.is_signed);
      dvs_d  = magnitude(req_i.divisor, req_i.is_signed);
      qneg_d = req_i.is_signed & (req_i.dividend[WIDTH-1] ^ req_i.divisor[WIDTH-1]);
      rneg_d = req_i.is_signed & req_i.dividend[WIDTH-1];
    end else if (state_q == MDU_RUN) begin
      rem_d = take ? WIDTH'(trial - {1'b0, dvs_q}) : trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], take};
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// EX-stage multiply/divide unit: HI/LO registers, single-cycle multiplier, iterative divider,
// and the HI/LO stall and read mux.
module mdu_hilo
  import mdu_hilo_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  mdu_hilo_if.slave  bus
);

  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   div_quot, div_rem;
  logic [2*WIDTH-1:0] mul_a, mul_b, product;
  logic               accept, has_div, has_mult, has_mthl, hilo_op;
  logic               do_div, do_mult, do_mthl, mul_signed;
  logic               div_busy, div_done;
  div_req_t           div_req;

  assign has_div  = bus.DIV[DIV_S_BIT]   | bus.DIV[DIV_U_BIT];
  assign has_mult = bus.MULT[MULT_S_BIT] | bus.MULT[MULT_U_BIT];
  assign has_mthl = bus.MTHL[MTHL_HI_BIT] | bus.MTHL[MTHL_LO_BIT];
  assign hilo_op  = has_div | has_mult | has_mthl
                  | bus.MFHL[MFHL_HI_BIT] | bus.MFHL[MFHL_LO_BIT];

  // Priority DIV > MULT > MTHL if the decoder ever presents more than one
  assign accept  = bus.in_valid & ~bus.cancel & ~div_busy;
  assign do_div  = accept & has_div;
  assign do_mult = accept & ~has_div & has_mult;
  assign do_mthl = accept & ~has_div & ~has_mult & has_mthl;

  assign div_req.is_signed = bus.DIV[DIV_S_BIT] & ~bus.DIV[DIV_U_BIT];
  assign div_req.dividend  = bus.src_a;
  assign div_req.divisor   = bus.src_b;

  mdu_hilo_div_iter_core u_div_iter_core (
    .clk      (clk),
    .rst_n    (resetn),
    .start_i  (do_div),
    .cancel_i (bus.cancel),
    .req_i    (div_req),
    .busy_o   (div_busy),
    .done_o   (div_done),
    .quot_o   (div_quot),
    .rem_o    (div_rem)
  );

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are exact either way
  assign mul_signed = bus.MULT[MULT_S_BIT] & ~bus.MULT[MULT_U_BIT];
  assign mul_a      = {{WIDTH{mul_signed & bus.src_a[WIDTH-1]}}, bus.src_a};
  assign mul_b      = {{WIDTH{mul_signed & bus.src_b[WIDTH-1]}}, bus.src_b};
  assign product    = mul_a * mul_b;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_done) begin
      lo_d = div_quot;
      hi_d = div_rem;
    end else if (do_mult) begin
      {hi_d, lo_d} = product;
    end else if (do_mthl) begin
      if (bus.MTHL[MTHL_HI_BIT]) hi_d = bus.src_a;
      if (bus.MTHL[MTHL_LO_BIT]) lo_d = bus.src_a;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign bus.busy       = div_busy;
  assign bus.stall      = div_busy & bus.in_valid & hilo_op;
  assign bus.hilo_rdata = bus.MFHL[MFHL_HI_BIT] ? hi_q : lo_q;

endmodule
